// File: rtl/apb_mod_pkg.sv
// Shared definitions for the APB register block: FSM state encoding,
// default bank geometry and the register reset value.
package apb_mod_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned NREGS_DEF  = 16;
  localparam int unsigned IDX_W_DEF  = 4;

  localparam logic [31:0] RST_VAL = '0;

endpackage

// File: rtl/apb_mod_top_regfile.sv
// apb_regfile: NREGS x DATA_W register storage with one synchronous write
// port, one combinational read port and synchronous active-high reset.
module apb_regfile
  import apb_mod_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned IDX_W  = IDX_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  widx_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  ridx_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [NREGS];

  // Storage update: reset clears every entry and takes priority over a write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem_q[IDX_W'(i)] <= DATA_W'(RST_VAL);
      end
    end else if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/apb_mod_top.sv
// apb_mod_top: zero-wait-state APB slave over a word-indexed register bank.
// Optional feature macro: APB_RD_CLEAR_EN -- when defined, PRDATA is cleared
// on every edge with PSELx low instead of holding the last read value.
module apb_mod_top
  import apb_mod_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned IDX_W  = IDX_W_DEF
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic [31:0]       PADDR,
  input  logic              PSELx,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA
);

  apb_state_t        state_q, state_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              commit;
  logic [DATA_W-1:0] rf_rdata;

  assign idx      = PADDR[IDX_W-1:0];
  assign in_range = ~|PADDR[31:IDX_W];

  // Next state follows the sampled strobes directly, from any state.
  always_comb begin
    state_d = state_q;
    if (!PSELx) begin
      state_d = IDLE;
    end else if (!PENABLE) begin
      state_d = SETUP;
    end else begin
      state_d = ACCESS;
    end
  end

  // A write commits only on the edge that enters ACCESS, so a held
  // PENABLE cannot re-commit; reset is folded in to drop a same-edge write.
  always_comb begin
    commit = PSELx && PENABLE && PWRITE && in_range &&
             (state_q != ACCESS) && !PRESETn;
  end

  // Read data selection: load on reads, otherwise hold or clear on idle.
  always_comb begin
    prdata_d = prdata_q;
    if (PSELx && !PWRITE) begin
      prdata_d = in_range ? rf_rdata : '0;
    end
`ifdef APB_RD_CLEAR_EN
    else if (!PSELx) begin
      prdata_d = '0;
    end
`else
`endif
  end

  // State and read-data registers with synchronous active-high reset.
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      state_q  <= IDLE;
      prdata_q <= DATA_W'(RST_VAL);
    end else begin
      state_q  <= state_d;
      prdata_q <= prdata_d;
    end
  end

  apb_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clk_i   (PCLK),
    .rst_i   (PRESETn),
    .we_i    (commit),
    .widx_i  (idx),
    .wdata_i (PWDATA),
    .ridx_i  (idx),
    .rdata_o (rf_rdata)
  );

  assign PRDATA = prdata_q;

endmodule

// File: tb/tb_apb_mod_top.sv
// Directed bench for apb_mod_top: reset, writes with and without SETUP,
// held ACCESS, out-of-range decode, reset during a transfer, idle PRDATA.
module tb_apb_mod_top;

  logic        PCLK;
  logic        PRESETn;
  logic [31:0] PADDR;
  logic        PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;

  int tests;
  int failed;

  apb_mod_top #(
    .DATA_W (32),
    .NREGS  (16),
    .IDX_W  (4)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PADDR   (PADDR),
    .PSELx   (PSELx),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Advance one rising edge; outputs are sampled and inputs changed 1ns later.
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] exp);
    tests++;
    assert (PRDATA === exp) else begin
      failed++;
      $error("FAIL %s: PRDATA=%h expected %h", tag, PRDATA, exp);
    end
  endtask

  task automatic go_idle();
    PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    tick();
  endtask

  // Read with SETUP; data must already be valid after the SETUP edge.
  task automatic read_setup(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    PADDR = addr; PWRITE = 1'b0; PSELx = 1'b1; PENABLE = 1'b0;
    tick();
    check({tag, "_setup"}, exp);
    PENABLE = 1'b1;
    tick();
    check({tag, "_access"}, exp);
  endtask

  // Read with PSELx and PENABLE first sampled together.
  task automatic read_direct(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    PADDR = addr; PWRITE = 1'b0; PSELx = 1'b1; PENABLE = 1'b1;
    tick();
    check(tag, exp);
  endtask

  task automatic write_xfer(input logic [31:0] addr, input logic [31:0] data);
    PADDR = addr; PWDATA = data; PWRITE = 1'b1; PSELx = 1'b1; PENABLE = 1'b0;
    tick();
    PENABLE = 1'b1;
    tick();
    go_idle();
  endtask

  initial begin
    tests = 0; failed = 0;
    PADDR = '0; PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PWDATA = '0;

    // 1: reset held 4 edges, then every index reads 0
    PRESETn = 1'b1;
    repeat (4) tick();
    PRESETn = 1'b0;
    tick();
    check("reset_prdata", 32'h0);
    for (int i = 0; i < 16; i++) begin
      read_setup(i, 32'h0, $sformatf("rst_rd%0d", i));
      go_idle();
    end

    // 2: write 4 to index 6, PENABLE held 3 edges; changed data must not re-commit
    PADDR = 32'd6; PWDATA = 32'd4; PWRITE = 1'b1; PSELx = 1'b1; PENABLE = 1'b0;
    tick();
    PENABLE = 1'b1;
    tick();
    PWDATA = 32'd9;
    tick();
    tick();
    go_idle();
    read_direct(32'd6, 32'd4, "wr6_once");
    for (int i = 0; i < 16; i++) begin
      if (i != 6) begin
        go_idle();
        read_direct(i, 32'h0, $sformatf("others0_%0d", i));
      end
    end
    go_idle();
    read_direct(32'd6, 32'd4, "rd6_again");

    // 6: drop PSELx after reading 4
    go_idle();
`ifdef APB_RD_CLEAR_EN
    check("idle_prdata1", 32'h0);
`else
    check("idle_prdata1", 32'd4);
`endif
    go_idle();
`ifdef APB_RD_CLEAR_EN
    check("idle_prdata2", 32'h0);
`else
    check("idle_prdata2", 32'd4);
`endif

    // 3: write without SETUP
    PADDR = 32'd3; PWDATA = 32'hDEADBEEF; PWRITE = 1'b1; PSELx = 1'b1; PENABLE = 1'b1;
    tick();
    go_idle();
    read_setup(32'd3, 32'hDEADBEEF, "direct_wr3");

    // 4: out-of-range write dropped, out-of-range read returns 0
    go_idle();
    write_xfer(32'h10, 32'h55);
    read_direct(32'd3, 32'hDEADBEEF, "oor_keep3");
    read_direct(32'h10, 32'h0, "oor_rd10");
    read_direct(32'd0, 32'h0, "oor_rd0");
    read_direct(32'd6, 32'd4, "oor_keep6");
    read_direct(32'h8000_0003, 32'h0, "oor_rd_hi");

    // 5a: reset mid-ACCESS of a write to 6; transfer dropped at release
    read_direct(32'd3, 32'hDEADBEEF, "pre_rst3");
    PADDR = 32'd6; PWDATA = 32'h77; PWRITE = 1'b1; PSELx = 1'b1; PENABLE = 1'b0;
    tick();
    PENABLE = 1'b1; PRESETn = 1'b1;
    tick();
    check("midrst_prdata", 32'h0);
    PRESETn = 1'b0;
    go_idle();
    check("rel_prdata", 32'h0);
    read_direct(32'd6, 32'h0, "midrst_rd6");
    read_direct(32'd3, 32'h0, "midrst_rd3");
    go_idle();

    // 5b: transfer held across reset release commits once on re-entry
    PADDR = 32'd6; PWDATA = 32'h77; PWRITE = 1'b1; PSELx = 1'b1; PENABLE = 1'b0;
    tick();
    PENABLE = 1'b1; PRESETn = 1'b1;
    tick();
    PRESETn = 1'b0;
    tick();
    PWDATA = 32'h88;
    tick();
    go_idle();
    read_setup(32'd6, 32'h77, "reentry_rd6");
    go_idle();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
